// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller and the RAM it fronts.
package mem_pkg;

  localparam int MEM_BITS     = 32;
  localparam int MEM_RAMSIZE  = 512;
  localparam int MEM_CPU_ADDR = 32;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_CAPTURE = 3'd2,
    WR_ISSUE   = 3'd3,
    RESP       = 3'd4
  } state_e;

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU-side request/response signals plus the RAM strobe/data bus of the controller.
interface mem_ctrl_if #(
  parameter int BITS     = mem_pkg::MEM_BITS,
  parameter int ADDR     = $clog2(mem_pkg::MEM_RAMSIZE),
  parameter int CPU_ADDR = mem_pkg::MEM_CPU_ADDR
);

  logic                req;
  logic                req_write;
  logic [CPU_ADDR-1:0] mar_in;
  logic [BITS-1:0]     mdr_in;
  logic                busy;
  logic                done;
  logic                err;
  logic [BITS-1:0]     mdr_out;
  logic                ram_read;
  logic                ram_write;
  logic [ADDR-1:0]     ram_address;
  logic [BITS-1:0]     ram_dataIn;
  logic [BITS-1:0]     ram_dataOut;

  // Environment side: the CPU datapath together with the RAM.
  modport master (
    output req, req_write, mar_in, mdr_in, ram_dataOut,
    input  busy, done, err, mdr_out, ram_read, ram_write, ram_address, ram_dataIn
  );

  modport slave (
    input  req, req_write, mar_in, mdr_in, ram_dataOut,
    output busy, done, err, mdr_out, ram_read, ram_write, ram_address, ram_dataIn
  );

endinterface

// File: rtl/mem_ctrl.sv
// Memory access controller: latches MAR/MDR on a request, sequences the RAM strobes
// and returns a one-cycle done (or err for out-of-range addresses).
module mem_ctrl #(
  parameter int BITS     = mem_pkg::MEM_BITS,
  parameter int RAMSIZE  = mem_pkg::MEM_RAMSIZE,
  parameter int ADDR     = $clog2(RAMSIZE),
  parameter int CPU_ADDR = mem_pkg::MEM_CPU_ADDR
) (
  input logic       clk,
  input logic       clr_n,
  mem_ctrl_if.slave bus
);
  import mem_pkg::*;

  state_e          state_q;
  logic [ADDR-1:0] mar_q;
  logic [BITS-1:0] mdr_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic            ram_read_q;
  logic            ram_write_q;
  logic            out_of_range_s;

  // Any set bit above the RAM address field means the word does not exist.
  assign out_of_range_s = (bus.mar_in[CPU_ADDR-1:ADDR] != {(CPU_ADDR-ADDR){1'b0}});

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.mdr_out     = mdr_q;
  assign bus.ram_read    = ram_read_q;
  assign bus.ram_write   = ram_write_q;
  assign bus.ram_address = mar_q;
  assign bus.ram_dataIn  = mdr_q;

  // Access sequencer; pulses and strobes default low so each lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      mar_q       <= {ADDR{1'b0}};
      mdr_q       <= {BITS{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            mar_q  <= bus.mar_in[ADDR-1:0];
            busy_q <= 1'b1;
            if (out_of_range_s) begin
              // Rejected requests leave the MDR untouched and never strobe the RAM.
              state_q <= RESP;
              err_q   <= 1'b1;
            end else if (bus.req_write) begin
              mdr_q       <= bus.mdr_in;
              state_q     <= WR_ISSUE;
              ram_write_q <= 1'b1;
            end else begin
              state_q    <= RD_ISSUE;
              ram_read_q <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RD_ISSUE: begin
          state_q <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          mdr_q   <= bus.ram_dataOut;
          state_q <= RESP;
          done_q  <= 1'b1;
        end
        WR_ISSUE: begin
          state_q <= RESP;
          done_q  <= 1'b1;
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl with a behavioural single-port RAM and a
// word-array reference model of memory contents and MDR.
module tb_mem_ctrl;

  localparam int BITS    = 32;
  localparam int RAMSIZE = 512;
  localparam int ADDR    = 9;
  localparam int CPU_A   = 32;

  logic clk;
  logic clr_n;

  mem_ctrl_if #(.BITS(BITS), .ADDR(ADDR), .CPU_ADDR(CPU_A)) bus ();

  mem_ctrl #(.BITS(BITS), .RAMSIZE(RAMSIZE), .ADDR(ADDR), .CPU_ADDR(CPU_A)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: samples strobes on the rising edge, registered read data.
  logic [BITS-1:0] ram_mem [RAMSIZE];
  logic [BITS-1:0] ram_dout;
  logic            pre_we;
  logic [ADDR-1:0] pre_addr;
  logic [BITS-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) ram_mem[pre_addr] <= pre_data;
    else if (bus.ram_write) ram_mem[bus.ram_address] <= bus.ram_dataIn;
    if (bus.ram_read) ram_dout <= ram_mem[bus.ram_address];
  end
  assign bus.ram_dataOut = ram_dout;

  int errors = 0;
  int checks = 0;

  // Reference model.
  logic [BITS-1:0] ref_mem [RAMSIZE];
  logic [BITS-1:0] model_mdr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle invariants.
  bit prev_pulse = 1'b0;
  always @(negedge clk) begin
    checks += 3;
    if (bus.ram_read && bus.ram_write) begin
      errors++;
      $display("FAIL strobe_excl: got read=1 write=1 expected not both");
    end
    if (bus.done && bus.err) begin
      errors++;
      $display("FAIL done_err_excl: got done=1 err=1 expected not both");
    end
    if (prev_pulse && (bus.done || bus.err)) begin
      errors++;
      $display("FAIL pulse_width: got done/err high two cycles expected one");
    end
    prev_pulse = bus.done || bus.err;
  end

  task automatic do_txn(input string tag, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit exp_err, input int exp_lat,
                        input logic [31:0] exp_mdr);
    int cyc, rdc, wrc, bsy;
    bit seen;
    @(negedge clk);
    bus.req = 1'b1; bus.req_write = wr; bus.mar_in = addr; bus.mdr_in = data;
    cyc = 0; rdc = 0; wrc = 0; bsy = 0; seen = 1'b0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      rdc += int'(bus.ram_read);
      wrc += int'(bus.ram_write);
      bsy += int'(bus.busy);
      if (bus.done || bus.err) begin
        seen = 1'b1;
        bus.req = 1'b0;
      end else begin
        // Junk with req held high while busy must be ignored.
        bus.req = 1'b1; bus.req_write = 1'($urandom);
        bus.mar_in = $urandom; bus.mdr_in = $urandom;
      end
    end
    bus.req = 1'b0;
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
    chk({tag, "_done"}, {31'd0, bus.done}, {31'd0, !exp_err});
    chk({tag, "_mdr"}, bus.mdr_out, exp_mdr);
    chk({tag, "_rd_strobes"}, 32'(rdc), 32'(!exp_err && !wr));
    chk({tag, "_wr_strobes"}, 32'(wrc), 32'(!exp_err && wr));
    chk({tag, "_busy_cycles"}, 32'(bsy), 32'(exp_lat));
    @(negedge clk);
    chk({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
    // Model update from the access rules.
    if (!exp_err && wr) ref_mem[addr[ADDR-1:0]] = data;
    model_mdr = exp_mdr;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          exp_err;
    int          exp_lat;
    logic [31:0] exp_mdr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int d1, d2;
    logic [31:0] m1, m2;
    bit ex_err, wr;
    int ex_lat, r;
    logic [31:0] addr, data, ex_mdr;

    vecs[0] = '{1'b0, 32'd85,          32'h0,         1'b0, 3, 32'h0000_F7F7};
    vecs[1] = '{1'b1, 32'd12,          32'hDEAD_BEEF, 1'b0, 2, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'd12,          32'h0,         1'b0, 3, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 32'd511,         32'h0,         1'b0, 3, 32'h5115_1151};
    vecs[4] = '{1'b0, 32'd512,         32'h0,         1'b1, 1, 32'h5115_1151};
    vecs[5] = '{1'b1, 32'h8000_0004,   32'h1234_5678, 1'b1, 1, 32'h5115_1151};
    vecs[6] = '{1'b0, 32'd4,           32'h0,         1'b0, 3, 32'h0080_0055};
    vecs[7] = '{1'b1, 32'd511,         32'hA5A5_0F0F, 1'b0, 2, 32'hA5A5_0F0F};
    vecs[8] = '{1'b0, 32'd0,           32'h0,         1'b0, 3, 32'h0BAD_F00D};

    clr_n = 1'b0;
    bus.req = 1'b0; bus.req_write = 1'b0; bus.mar_in = 32'd0; bus.mdr_in = 32'd0;
    pre_we = 1'b0; pre_addr = 9'd0; pre_data = 32'd0;
    for (int i = 0; i < RAMSIZE; i++) ref_mem[i] = $urandom;
    ref_mem[85] = 32'h0000_F7F7;
    ref_mem[4] = 32'h0080_0055;
    ref_mem[511] = 32'h5115_1151;
    ref_mem[0] = 32'h0BAD_F00D;
    for (int i = 0; i < RAMSIZE; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 9'(i); pre_data = ref_mem[i];
    end
    @(negedge clk);
    pre_we = 1'b0;
    model_mdr = 32'd0;

    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_mdr", bus.mdr_out, 32'd0);
    chk("rst_ram_read", {31'd0, bus.ram_read}, 32'd0);
    chk("rst_ram_write", {31'd0, bus.ram_write}, 32'd0);
    chk("rst_address", {23'd0, bus.ram_address}, 32'd0);
    clr_n = 1'b1;

    for (int i = 0; i < 9; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
             vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_mdr);

    // Back-to-back reads with req held high: done pulses 4 cycles apart.
    @(negedge clk);
    bus.req = 1'b1; bus.req_write = 1'b0; bus.mar_in = 32'd4;
    d1 = 0; d2 = 0; m1 = 32'd0; m2 = 32'd0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.done) begin
        if (d1 == 0) begin
          d1 = c; m1 = bus.mdr_out; bus.mar_in = 32'd85;
        end else if (d2 == 0) begin
          d2 = c; m2 = bus.mdr_out; bus.req = 1'b0;
        end
      end
    end
    bus.req = 1'b0;
    chk("b2b_first_done", 32'(d1), 32'd3);
    chk("b2b_second_done", 32'(d2), 32'd7);
    chk("b2b_first_data", m1, 32'h0080_0055);
    chk("b2b_second_data", m2, 32'h0000_F7F7);
    model_mdr = 32'h0000_F7F7;

    // Reset during RD_CAPTURE aborts the read.
    @(negedge clk);
    bus.req = 1'b1; bus.req_write = 1'b0; bus.mar_in = 32'd4;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_mdr", bus.mdr_out, 32'd0);
    chk("midrst_strobes", {30'd0, bus.ram_read, bus.ram_write}, 32'd0);
    d1 = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.done || bus.err || bus.busy) d1++;
    end
    chk("midrst_quiet", 32'(d1), 32'd0);
    model_mdr = 32'd0;

    // Randomised transactions against the reference model.
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) addr = 32'd511;
      else if (r == 1) addr = 32'd512;
      else if (r == 2) addr = $urandom | 32'h0000_0200;
      else addr = $urandom_range(0, RAMSIZE - 1);
      data = $urandom;
      ex_err = (addr >= RAMSIZE);
      ex_lat = ex_err ? 1 : (wr ? 2 : 3);
      ex_mdr = ex_err ? model_mdr : (wr ? data : ref_mem[addr[ADDR-1:0]]);
      do_txn($sformatf("rnd%0d", n), wr, addr, data, ex_err, ex_lat, ex_mdr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
